// File: rtl/median_window_feeder.sv
// Builds 3x3 windows from a raster pixel stream using two line buffers, loads each
// interior window serially into the median core and returns its result over valid/ready.
module median_window_feeder #(
    parameter int SIZE   = 8,
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 16
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic [SIZE-1:0] PIX_IN,
    input  logic            PIX_VALID,
    output logic            PIX_READY,
    output logic [SIZE-1:0] MED_DI,
    output logic            MED_DSI,
    input  logic [SIZE-1:0] MED_DO,
    input  logic            MED_DSO,
    output logic [SIZE-1:0] OUT_PIX,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic            OUT_LAST
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    typedef enum logic [1:0] {
        ST_ACCEPT,
        ST_LOAD,
        ST_WAIT,
        ST_OUT
    } state_t;

    state_t        state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [3:0]    ld_idx;
    logic          last_win;

    logic [SIZE-1:0] lb0 [WIDTH];
    logic [SIZE-1:0] lb1 [WIDTH];
    // Row-major window: win[0..2] top row, win[6..8] bottom row (newest line).
    logic [SIZE-1:0] win [9];

    logic acc;
    logic win_done;
    logic frame_end;

    assign acc       = PIX_VALID & PIX_READY;
    assign win_done  = (row >= RW'(2)) && (col >= CW'(2));
    assign frame_end = (row == ROW_LAST) && (col == COL_LAST);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= ST_ACCEPT;
            col       <= '0;
            row       <= '0;
            ld_idx    <= '0;
            last_win  <= 1'b0;
            PIX_READY <= 1'b0;
            MED_DSI   <= 1'b0;
            MED_DI    <= '0;
            OUT_VALID <= 1'b0;
            OUT_PIX   <= '0;
            OUT_LAST  <= 1'b0;
        end else begin
            case (state)
                ST_ACCEPT: begin
                    PIX_READY <= 1'b1;
                    if (acc) begin
                        if (col == COL_LAST) begin
                            col <= '0;
                            row <= frame_end ? '0 : row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                        if (win_done) begin
                            // win[1] becomes the top-left element once this accept shifts the window
                            state     <= ST_LOAD;
                            PIX_READY <= 1'b0;
                            MED_DSI   <= 1'b1;
                            MED_DI    <= win[1];
                            ld_idx    <= '0;
                            last_win  <= frame_end;
                        end
                    end
                end
                ST_LOAD: begin
                    if (ld_idx == 4'd8) begin
                        state   <= ST_WAIT;
                        MED_DSI <= 1'b0;
                        MED_DI  <= '0;
                    end else begin
                        ld_idx <= ld_idx + 4'd1;
                        MED_DI <= win[ld_idx + 4'd1];
                    end
                end
                ST_WAIT: begin
                    if (MED_DSO) begin
                        OUT_PIX   <= MED_DO;
                        OUT_LAST  <= last_win;
                        OUT_VALID <= 1'b1;
                        state     <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (OUT_READY) begin
                        OUT_VALID <= 1'b0;
                        PIX_READY <= 1'b1;
                        state     <= ST_ACCEPT;
                    end
                end
                default: state <= ST_ACCEPT;
            endcase
        end
    end

    // Pixel storage is never reset: row/col gating keeps stale entries out of any loaded window.
    always_ff @(posedge CLK) begin
        if (acc) begin
            win[0]   <= win[1];
            win[1]   <= win[2];
            win[2]   <= lb1[col];
            win[3]   <= win[4];
            win[4]   <= win[5];
            win[5]   <= lb0[col];
            win[6]   <= win[7];
            win[7]   <= win[8];
            win[8]   <= PIX_IN;
            lb1[col] <= lb0[col];
            lb0[col] <= PIX_IN;
        end
    end

endmodule

// File: tb/tb_median_window_feeder.sv
// Self-checking bench for median_window_feeder: behavioural median core plus a
// frame-level reference model that derives every window and median from the raw frame.
module tb_median_window_feeder;

    localparam int SIZE   = 8;
    localparam int WIDTH  = 16;
    localparam int HEIGHT = 16;
    localparam int NOUT   = (WIDTH - 2) * (HEIGHT - 2);

    logic            CLK = 1'b0;
    logic            nRST = 1'b0;
    logic [SIZE-1:0] PIX_IN = '0;
    logic            PIX_VALID = 1'b0;
    logic            PIX_READY;
    logic [SIZE-1:0] MED_DI;
    logic            MED_DSI;
    logic [SIZE-1:0] MED_DO = '0;
    logic            MED_DSO = 1'b0;
    logic [SIZE-1:0] OUT_PIX;
    logic            OUT_VALID;
    logic            OUT_READY = 1'b0;
    logic            OUT_LAST;

    median_window_feeder #(.SIZE(SIZE), .WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
        .CLK(CLK), .nRST(nRST),
        .PIX_IN(PIX_IN), .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY),
        .MED_DI(MED_DI), .MED_DSI(MED_DSI), .MED_DO(MED_DO), .MED_DSO(MED_DSO),
        .OUT_PIX(OUT_PIX), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_LAST(OUT_LAST)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int          kind;
        int          arg;
        int          lat;
        int          exp_count;
        logic [7:0]  exp_first;
        logic [7:0]  exp_last;
        int          exp_nlast;
    } vec_t;

    logic [7:0]  frm [HEIGHT][WIDTH];
    logic [8:0]  exp_out [$];
    logic [71:0] exp_win [$];

    int         rdy_mode = 0;     // 0: always ready, 1: random, 2: held low
    int         core_lat = 41;
    int         core_lat_max = 0; // non-zero: random latency 1..core_lat_max
    bit         inj_en = 1'b0;
    bit         gap_en = 1'b0;
    bit         aborted = 1'b0;
    int         n_out = 0;
    int         n_last = 0;
    logic [7:0] first_pix = '0;
    logic [7:0] last_pix = '0;
    int         last_acc = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic check_w(input string name, input logic [71:0] act, input logic [71:0] req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [7:0] med9(input logic [71:0] w);
        logic [7:0] a [9];
        logic [7:0] t;
        for (int i = 0; i < 9; i++) a[i] = w[71-8*i -: 8];
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8 - i; j++)
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
        return a[4];
    endfunction

    // Every window whose bottom-right pixel is (r,c) with r,c >= 2, in raster order.
    task automatic build_expect();
        logic [71:0] w;
        for (int r = 2; r < HEIGHT; r++)
            for (int c = 2; c < WIDTH; c++) begin
                w = '0;
                for (int dr = 0; dr < 3; dr++)
                    for (int dc = 0; dc < 3; dc++)
                        w = {w[63:0], frm[r-2+dr][c-2+dc]};
                exp_win.push_back(w);
                exp_out.push_back({(r == HEIGHT-1 && c == WIDTH-1), med9(w)});
            end
    endtask

    task automatic fill(input int kind, input int arg);
        for (int r = 0; r < HEIGHT; r++)
            for (int c = 0; c < WIDTH; c++)
                case (kind)
                    0:       frm[r][c] = arg[7:0];
                    1:       frm[r][c] = 8'(r * WIDTH + c);
                    2:       frm[r][c] = (r == arg / 16 && c == arg % 16) ? 8'hFF : 8'h00;
                    default: frm[r][c] = 8'($urandom);
                endcase
    endtask

    // Behavioural median core: collects the DSI burst, answers after a latency counted from DSI falling.
    logic [7:0]  dq [$];
    bit          busy = 1'b0;
    int          wcnt = 0;
    logic [7:0]  pend = '0;
    logic [71:0] got_w;
    always @(negedge CLK) begin
        if (!nRST) begin
            dq.delete();
            busy = 1'b0;
            MED_DSO = 1'b0;
        end else begin
            MED_DSO = 1'b0;
            if (busy) begin
                wcnt--;
                if (wcnt <= 0) begin
                    MED_DSO = 1'b1;
                    MED_DO  = pend;
                    busy    = 1'b0;
                end
            end
            if (MED_DSI) begin
                dq.push_back(MED_DI);
            end else if (dq.size() != 0) begin
                got_w = '0;
                foreach (dq[i]) got_w = {got_w[63:0], dq[i]};
                check("dsi_burst_len", dq.size(), 9);
                check("window_expected", int'(exp_win.size() != 0), 1);
                if (exp_win.size() != 0) check_w("di_sequence", got_w, exp_win.pop_front());
                pend = med9(got_w);
                busy = 1'b1;
                wcnt = (core_lat_max > 0) ? int'($urandom_range(1, core_lat_max)) : core_lat;
                dq.delete();
            end
            if (inj_en && !busy && !MED_DSO && $urandom_range(0, 15) == 0) begin
                MED_DSO = 1'b1;
                MED_DO  = 8'($urandom);
            end
        end
    end

    // Output sink: choose OUT_READY for the coming edge, then score the handshake it implies.
    logic [8:0] e;
    always @(negedge CLK) begin
        case (rdy_mode)
            0:       OUT_READY = 1'b1;
            1:       OUT_READY = ($urandom_range(0, 2) != 0);
            default: OUT_READY = 1'b0;
        endcase
        if (nRST && OUT_VALID && OUT_READY) begin
            check("output_expected", int'(exp_out.size() != 0), 1);
            if (exp_out.size() != 0) begin
                e = exp_out.pop_front();
                check("out_pix", int'(OUT_PIX), int'(e[7:0]));
                check("out_last", int'(OUT_LAST), int'(e[8]));
            end
            if (n_out == 0) first_pix = OUT_PIX;
            last_pix = OUT_PIX;
            n_out++;
            if (OUT_LAST) n_last++;
        end
    end

    task automatic send_pix(input logic [7:0] p);
        int n;
        if (aborted) return;
        if (gap_en)
            while ($urandom_range(0, 3) == 0) begin
                @(negedge CLK);
                PIX_VALID = 1'b0;
                PIX_IN    = 8'($urandom);
            end
        @(negedge CLK);
        PIX_IN    = p;
        PIX_VALID = 1'b1;
        n = 0;
        while (!PIX_READY && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (!PIX_READY) begin
            checks++;
            errors++;
            aborted = 1'b1;
            $display("FAIL pix_ready_timeout: PIX_READY low for %0d cycles, required high within 2000", n);
        end
        last_acc = cyc + 1;
    endtask

    task automatic send_range(input int from, input int to);
        for (int i = from; i < to && !aborted; i++) send_pix(frm[i / WIDTH][i % WIDTH]);
    endtask

    task automatic drain();
        int n;
        @(negedge CLK);
        PIX_VALID = 1'b0;
        n = 0;
        while ((exp_out.size() != 0 || OUT_VALID) && n < 5000 && !aborted) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 5000) begin
            checks++;
            errors++;
            aborted = 1'b1;
            $display("FAIL drain_timeout: %0d outputs pending, required 0", exp_out.size());
        end
        check("windows_consumed", exp_win.size(), 0);
    endtask

    task automatic start_frame(input int lat);
        core_lat     = lat;
        core_lat_max = 0;
        n_out        = 0;
        n_last       = 0;
        first_pix    = '0;
        last_pix     = '0;
        build_expect();
    endtask

    task automatic do_reset();
        @(negedge CLK);
        nRST      = 1'b0;
        PIX_VALID = 1'b0;
        repeat (2) @(negedge CLK);
        exp_out.delete();
        exp_win.delete();
        nRST = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        repeat (95000) @(posedge CLK);
        $display("FAIL watchdog: run exceeded 95000 cycles, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl [5];
        int   ab_d [3];
        int   ab_dsi [3];
        int   ab_ov [3];
        int   n;
        int   t;
        int   bad_ready;
        int   stall_bad;

        tbl[0] = '{0, 8'h55, 41, NOUT, 8'h55, 8'h55, 1};
        tbl[1] = '{1, 0,     41, NOUT, 8'h11, 8'hEE, 1};
        tbl[2] = '{2, 8'h77,  5, NOUT, 8'h00, 8'h00, 1};
        tbl[3] = '{2, 8'h00,  5, NOUT, 8'h00, 8'h00, 1};
        tbl[4] = '{2, 8'hFF,  5, NOUT, 8'h00, 8'h00, 1};
        ab_d   = '{4, 20, 60};
        ab_dsi = '{1, 0, 0};
        ab_ov  = '{0, 0, 1};

        // Reset state
        repeat (3) @(negedge CLK);
        check("rst_pix_ready", int'(PIX_READY), 0);
        check("rst_med_dsi", int'(MED_DSI), 0);
        check("rst_med_di", int'(MED_DI), 0);
        check("rst_out_valid", int'(OUT_VALID), 0);
        check("rst_out_pix", int'(OUT_PIX), 0);
        check("rst_out_last", int'(OUT_LAST), 0);
        nRST = 1'b1;
        repeat (2) @(negedge CLK);
        check("ready_after_reset", int'(PIX_READY), 1);

        // Whole frames with ideal core, back to back
        for (int k = 0; k < 5; k++) begin
            fill(tbl[k].kind, tbl[k].arg);
            start_frame(tbl[k].lat);
            send_range(0, WIDTH * HEIGHT);
            drain();
            check($sformatf("vec%0d_count", k), n_out, tbl[k].exp_count);
            check($sformatf("vec%0d_first", k), int'(first_pix), int'(tbl[k].exp_first));
            check($sformatf("vec%0d_last", k), int'(last_pix), int'(tbl[k].exp_last));
            check($sformatf("vec%0d_nlast", k), n_last, tbl[k].exp_nlast);
        end

        // Latency, back-pressure and ready gating on the first ramp window
        fill(1, 0);
        start_frame(41);
        rdy_mode = 2;
        send_range(0, 2 * WIDTH + 3);
        t = last_acc;
        @(negedge CLK);
        PIX_IN    = 8'hA5;
        PIX_VALID = 1'b1;
        bad_ready = 0;
        n = 0;
        while (!OUT_VALID && n < 200) begin
            if (PIX_READY) bad_ready++;
            @(negedge CLK);
            n++;
        end
        check("out_valid_latency", cyc - t, 51);
        stall_bad = 0;
        repeat (20) begin
            if (!OUT_VALID || OUT_PIX != 8'h11 || PIX_READY) stall_bad++;
            @(negedge CLK);
        end
        check("ready_low_while_busy", bad_ready, 0);
        check("stall_stable", stall_bad, 0);
        check("stall_out_pix", int'(OUT_PIX), 8'h11);
        PIX_VALID = 1'b0;
        rdy_mode  = 0;
        n = 0;
        while (OUT_VALID && n < 10) begin
            @(negedge CLK);
            n++;
        end
        check("valid_drop_after_handshake", int'(OUT_VALID), 0);
        check("ready_after_handshake", int'(PIX_READY), 1);
        send_range(2 * WIDTH + 3, WIDTH * HEIGHT);
        drain();
        check("timing_frame_count", n_out, NOUT);

        // Reset aborts a window in LOAD, WAIT and OUT
        for (int k = 0; k < 3; k++) begin
            do_reset();
            fill(1, 0);
            start_frame(41);
            rdy_mode = 2;
            send_range(0, 2 * WIDTH + 3);
            repeat (ab_d[k]) @(negedge CLK);
            check($sformatf("pre_abort%0d_dsi", k), int'(MED_DSI), ab_dsi[k]);
            check($sformatf("pre_abort%0d_valid", k), int'(OUT_VALID), ab_ov[k]);
            nRST      = 1'b0;
            PIX_VALID = 1'b0;
            #1;
            check($sformatf("abort%0d_zero_outputs", k),
                  int'({PIX_READY, MED_DSI, MED_DI, OUT_VALID, OUT_PIX, OUT_LAST}), 0);
        end
        do_reset();
        rdy_mode = 0;

        // Fresh frame after the abort must not emit any stale window
        fill(3, 0);
        start_frame(3);
        send_range(0, WIDTH * HEIGHT);
        drain();
        check("fresh_frame_count", n_out, NOUT);

        // Randomised frames: input gaps, output stalls, variable core latency, stray DSO pulses
        gap_en = 1'b1;
        inj_en = 1'b1;
        rdy_mode = 1;
        fill(3, 0);
        start_frame(0);
        core_lat_max = 12;
        send_range(0, WIDTH * HEIGHT);
        fill(3, 0);
        build_expect();
        send_range(0, WIDTH * HEIGHT);
        drain();
        check("random_count", n_out, 2 * NOUT);
        check("random_nlast", n_last, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/median_window_feeder.md
Name: median_window_feeder

Overview:
Upstream stage of the 3x3 median filter core. Accepts a raster-order pixel stream of one WIDTH x HEIGHT frame and buffers the two previous lines. For every interior window it serialises the 9 neighbourhood pixels into the median core's DI/DSI interface, waits for DSO, and captures DO. Each filtered pixel is presented on a valid/ready output, giving a (WIDTH-2) x (HEIGHT-2) output frame.

Parameters:
SIZE, 8, pixel width in bits (matches median core SIZE)
WIDTH, 16, pixels per line (>=3)
HEIGHT, 16, lines per frame (>=3)

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  asynchronous active-low reset
PIX_IN  input  SIZE  incoming raster pixel
PIX_VALID  input  1  PIX_IN valid
PIX_READY  output  1  feeder can accept PIX_IN this cycle
MED_DI  output  SIZE  pixel to median core DI
MED_DSI  output  1  to median core DSI; high while loading the 9 window pixels
MED_DO  input  SIZE  median core result
MED_DSO  input  1  median core result valid
OUT_PIX  output  SIZE  filtered pixel
OUT_VALID  output  1  OUT_PIX valid
OUT_READY  input  1  downstream accepts OUT_PIX
OUT_LAST  output  1  qualifies OUT_VALID; last filtered pixel of the frame

Behaviour:
- Reset (async, nRST=0): state=ACCEPT, col=0, row=0, load index=0. Outputs: PIX_READY=0 while nRST=0, then 1 in ACCEPT. MED_DSI=0, MED_DI=0, OUT_VALID=0, OUT_PIX=0, OUT_LAST=0. Line-buffer and window contents are not reset; the row/col gating guarantees no stale window is ever used.
- Storage: two line buffers LB0 (line row-1) and LB1 (line row-2), WIDTH x SIZE each, plus a 3x3 window register W[r][c].
- Accept: a pixel is taken when PIX_VALID & PIX_READY at a rising edge. On accept:
  - shift W left one column; new right column = {LB1[col], LB0[col], PIX_IN} (top to bottom);
  - LB1[col] <= LB0[col]; LB0[col] <= PIX_IN;
  - col increments; at WIDTH-1 it wraps to 0 and row increments; at the frame end (row=HEIGHT-1, col=WIDTH-1) both wrap to 0.
- Window complete: an accept with row>=2 and col>=2 (pre-increment values) moves the FSM to LOAD. Any other accept stays in ACCEPT, so border pixels stream at 1 per cycle with no output.
- FSM states:
  - ACCEPT: PIX_READY=1.
  - LOAD: PIX_READY=0, MED_DSI=1 for exactly 9 consecutive cycles. MED_DI order is W[0][0], W[0][1], W[0][2], W[1][0], ... W[2][2]. After 9 cycles go to WAIT.
  - WAIT: MED_DSI=0, MED_DI=0. On the first edge with MED_DSO=1: OUT_PIX <= MED_DO, OUT_LAST <= (this window ended the frame), go to OUT.
  - OUT: OUT_VALID=1; OUT_PIX/OUT_LAST held stable. When OUT_VALID & OUT_READY: OUT_VALID drops next cycle and the FSM returns to ACCEPT. PIX_READY stays 0 throughout OUT; there is no accept in the handshake cycle.
- Latency with the team median core (DSO asserts 41 edges after DSI falls): OUT_VALID rises 51 edges after the accepting edge. Minimum spacing between window accepts is 53 cycles.
- MED_DSO is ignored outside WAIT. No timeout: WAIT holds until DSO.
- PIX_VALID deasserted in ACCEPT causes no state change. PIX_IN is ignored when PIX_READY=0.
- nRST asserted mid-LOAD/WAIT/OUT aborts the window: MED_DSI drops immediately and the frame restarts at row 0, col 0.

Test Plan:
- Constant frame (16x16, all 0x55) with ideal median model -> 196 outputs, all 0x55; OUT_LAST=1 only on the 196th.
- Ramp frame PIX=row*16+col -> each output equals its centre pixel, e.g. first output 0x11; DSI pattern exactly 9 high cycles with DI sequence 0x00,0x01,0x02,0x10,0x11,0x12,0x20,0x21,0x22.
- Single-pixel impulse 0xFF in a zero frame -> all outputs 0x00 (impulse removed).
- Timing check: accept pixel (2,2) at edge t -> OUT_VALID rises after edge t+51; PIX_READY=0 from t+1 until the cycle after the output handshake.
- OUT_READY held low for 20 cycles -> OUT_VALID/OUT_PIX stable, PIX_READY=0; release -> handshake, then ACCEPT.
- nRST pulsed in WAIT -> all outputs 0 immediately; a fresh frame then produces correct outputs with no stale window emitted.
